// File: rtl/ad_cap_pkg.sv
// rtl/ad_cap_pkg.sv - shared state and channel-select encodings for the ADC capture controller
package ad_cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

  typedef enum logic [1:0] {
    CH_SEL_CH1  = 2'd0,
    CH_SEL_CH2  = 2'd1,
    CH_SEL_ILV  = 2'd2,
    CH_SEL_RSVD = 2'd3
  } ch_sel_t;

endpackage

// File: rtl/ad_trig_detect.sv
// rtl/ad_trig_detect.sv - threshold crossing detector on consecutive trigger-channel samples
module ad_trig_detect #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              rise,
  output logic              hit
);

  logic [DATA_W-1:0] prev_sample;
  logic              prev_valid;

  // Remember the last trigger-channel sample; clear forgets it so the first sample after arm cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sample <= '0;
      prev_valid  <= 1'b0;
    end else if (clear) begin
      prev_valid  <= 1'b0;
    end else if (sample_valid) begin
      prev_sample <= sample;
      prev_valid  <= 1'b1;
    end
  end

  // Unsigned crossing test between the stored and the current sample.
  always_comb begin
    hit = 1'b0;
    if (sample_valid && prev_valid) begin
      if (rise) hit = (prev_sample < level) && (sample >= level);
      else      hit = (prev_sample > level) && (sample <= level);
    end
  end

endmodule

// File: rtl/ad_capture_ctrl.sv
// rtl/ad_capture_ctrl.sv - pre/post trigger ADC capture into a circular RAM; FORCE_TRIG_EN adds force_trig
module ad_capture_ctrl
  import ad_cap_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int ADDR_W     = 10,
  parameter int POST_DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ad_data_in_1,
  input  logic [DATA_W-1:0] ad_data_in_2,
  input  logic              ad_valid,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        ch_sel,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rise,
`ifdef FORCE_TRIG_EN
  input  logic              force_trig,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W:0]   wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr
);

  localparam int PRE_DEPTH = (1 << ADDR_W) - POST_DEPTH;
  localparam logic [ADDR_W-1:0] PRE_DEPTH_A = ADDR_W'(PRE_DEPTH);
  localparam logic [ADDR_W-1:0] PRE_LAST    = ADDR_W'(PRE_DEPTH - 1);
  // The triggering sample is the first POST write, so POST itself counts POST_DEPTH-1 more.
  localparam logic [ADDR_W-1:0] POST_LAST   = ADDR_W'((POST_DEPTH > 1) ? POST_DEPTH - 2 : 0);

  cap_state_t        state, state_nxt;
  ch_sel_t           cfg_ch;
  logic [DATA_W-1:0] cfg_level;
  logic              cfg_rise;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic              ilv_ch2;

  logic              capturing, take, arm_ok, sel_ch2, trig_sample_valid;
  logic              det_hit, trig_hit, trig_fire, phase_end;
  logic [DATA_W-1:0] cur_sample;

  assign capturing  = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign take       = capturing && ad_valid && !abort;
  assign arm_ok     = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign sel_ch2    = (cfg_ch == CH_SEL_CH2) || ((cfg_ch == CH_SEL_ILV) && ilv_ch2);
  assign cur_sample = sel_ch2 ? ad_data_in_2 : ad_data_in_1;
  // In interleave mode only the ch1 half of the stream feeds the trigger.
  assign trig_sample_valid = take && !((cfg_ch == CH_SEL_ILV) && ilv_ch2);

  ad_trig_detect #(.DATA_W(DATA_W)) u_trig_detect (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (arm_ok),
    .sample_valid (trig_sample_valid),
    .sample       (cur_sample),
    .level        (cfg_level),
    .rise         (cfg_rise),
    .hit          (det_hit)
  );

`ifdef FORCE_TRIG_EN
  assign trig_hit = det_hit || (force_trig && take);
`else
  assign trig_hit = det_hit;
`endif

  assign trig_fire = (state == ST_WAIT_TRIG) && trig_hit;
  assign phase_end = ((state == ST_PRE) && (cnt == PRE_LAST)) || trig_fire;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; abort overrides everything including arm.
  always_comb begin
    state_nxt = state;
    busy      = capturing;
    done      = (state == ST_DONE);
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (arm) state_nxt = ST_PRE;
        ST_PRE:           if (take && (cnt == PRE_LAST)) state_nxt = ST_WAIT_TRIG;
        ST_WAIT_TRIG:     if (trig_fire) state_nxt = (POST_DEPTH > 1) ? ST_POST : ST_DONE;
        ST_POST:          if (take && (cnt == POST_LAST)) state_nxt = ST_DONE;
        default:          state_nxt = ST_IDLE;
      endcase
    end
  end

  // Capture datapath: config latch at arm, one-cycle registered RAM write, phase counter, start address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      start_addr <= '0;
      cfg_ch     <= CH_SEL_CH1;
      cfg_level  <= '0;
      cfg_rise   <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      ilv_ch2    <= 1'b0;
    end else begin
      wr_en <= take;
      if (arm_ok) begin
        cfg_ch    <= (ch_sel == CH_SEL_RSVD) ? CH_SEL_CH1 : ch_sel_t'(ch_sel);
        cfg_level <= trig_level;
        cfg_rise  <= trig_rise;
        ptr       <= '0;
        wr_addr   <= '0;
        cnt       <= '0;
        ilv_ch2   <= 1'b0;
      end else if (take) begin
        wr_addr <= ptr;
        wr_data <= {sel_ch2, cur_sample};
        ptr     <= ptr + 1'b1;
        ilv_ch2 <= (cfg_ch == CH_SEL_ILV) && !ilv_ch2;
        cnt     <= phase_end ? '0 : cnt + 1'b1;
        // Oldest retained sample sits PRE_DEPTH slots behind the trigger in the ring.
        if (trig_fire) start_addr <= ptr - PRE_DEPTH_A;
      end
    end
  end

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// tb/tb_ad_capture_ctrl.sv - directed table-driven bench for ad_capture_ctrl (ADDR_W=4, POST_DEPTH=8)
module tb_ad_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic [11:0] ad_data_in_1, ad_data_in_2;
  logic        ad_valid, arm, abort;
  logic [1:0]  ch_sel;
  logic [11:0] trig_level;
  logic        trig_rise;
`ifdef FORCE_TRIG_EN
  logic        force_trig;
`endif
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [12:0] wr_data;
  logic        busy, done;
  logic [3:0]  start_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_vec  = -1;

  ad_capture_ctrl #(.DATA_W(12), .ADDR_W(4), .POST_DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ad_data_in_1 (ad_data_in_1),
    .ad_data_in_2 (ad_data_in_2),
    .ad_valid     (ad_valid),
    .arm          (arm),
    .abort        (abort),
    .ch_sel       (ch_sel),
    .trig_level   (trig_level),
    .trig_rise    (trig_rise),
`ifdef FORCE_TRIG_EN
    .force_trig   (force_trig),
`endif
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .start_addr   (start_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] level;
    logic        rise;
    logic [11:0] d1_start, d1_step, d2_start, d2_step;
    int          n;          // samples fed after arm
    int          fire;       // write index expected to trigger, -1 for none
    int          force_idx;  // write index with force_trig high, -1 for none
    logic [3:0]  exp_start;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d act=%0h exp=%0h", name, cur_vec, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] val(input logic [11:0] s, input logic [11:0] st, input int k);
    logic [31:0] t;
    t = {20'd0, s} + {20'd0, st} * k;
    return t[11:0];
  endfunction

  task automatic run_vec(input vec_t v);
    int k;
    logic [11:0] d1, d2;
    logic tag;
    ch_sel = v.ch; trig_level = v.level; trig_rise = v.rise;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_addr", wr_addr, 0);
    chk("arm_wr_en", wr_en, 0);
    for (int i = 0; i < v.n; i++) begin
      k   = (v.ch == 2'd2) ? i / 2 : i;
      d1  = val(v.d1_start, v.d1_step, k);
      d2  = val(v.d2_start, v.d2_step, k);
      tag = (v.ch == 2'd1) || ((v.ch == 2'd2) && (i % 2 == 1));
      ad_data_in_1 = d1; ad_data_in_2 = d2; ad_valid = 1'b1;
`ifdef FORCE_TRIG_EN
      force_trig = (i == v.force_idx);
`endif
      tick();
      chk("wr_en", wr_en, 1);
      chk("wr_addr", wr_addr, i % 16);
      chk("wr_data", wr_data, {tag, tag ? d2 : d1});
      chk("done", done, (v.fire >= 0) && (i == v.n - 1));
    end
`ifdef FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    if (v.fire >= 0) begin
      chk("end_busy", busy, 0);
      chk("start_addr", start_addr, v.exp_start);
      tick();
      chk("done_no_write", wr_en, 0);
      chk("done_hold", done, 1);
    end else begin
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
    end
    ad_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; ad_data_in_1 = '0; ad_data_in_2 = '0; ad_valid = 1'b0;
    arm = 1'b0; abort = 1'b0; ch_sel = '0; trig_level = '0; trig_rise = 1'b0;
`ifdef FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    //          ch     level   rise  d1s     d1st    d2s     d2st    n   fire force start
    vecs.push_back('{2'd0, 12'h800, 1'b1, 12'h000, 12'h100, 12'h000, 12'h000, 16, 8,  -1, 4'd0});
    vecs.push_back('{2'd0, 12'h300, 1'b1, 12'h000, 12'h100, 12'h000, 12'h000, 18, -1, -1, 4'd0});
    vecs.push_back('{2'd2, 12'h800, 1'b1, 12'h100, 12'h000, 12'h000, 12'h100, 20, -1, -1, 4'd0});
    vecs.push_back('{2'd2, 12'h400, 1'b1, 12'h000, 12'h100, 12'hFFF, 12'h000, 16, 8,  -1, 4'd0});
    vecs.push_back('{2'd1, 12'h700, 1'b0, 12'h000, 12'h000, 12'hF00, 12'hF00, 16, 8,  -1, 4'd0});
    vecs.push_back('{2'd3, 12'hA80, 1'b1, 12'h000, 12'h100, 12'h000, 12'h000, 19, 11, -1, 4'd3});
`ifdef FORCE_TRIG_EN
    vecs.push_back('{2'd0, 12'h800, 1'b1, 12'h100, 12'h000, 12'h000, 12'h000, 19, 11, 11, 4'd3});
`endif

    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", start_addr, 0);
    rst_n = 1'b1;
    tick();

    // Abort in POST, arm ignored while busy, arm+abort together.
    ch_sel = 2'd0; trig_level = 12'h800; trig_rise = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ad_data_in_1 = 12'(i * 256); ad_valid = 1'b1; arm = (i == 3);
      tick(); arm = 1'b0;
      if (i == 3) chk("arm_ignored_addr", wr_addr, 3);
    end
    chk("post_busy", busy, 1);
    ad_data_in_1 = 12'hA00; abort = 1'b1; tick(); abort = 1'b0; ad_valid = 1'b0;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", busy, 0);
    chk("arm_abort_done", done, 0);
    ad_valid = 1'b1; tick(); ad_valid = 1'b0;
    chk("idle_no_write", wr_en, 0);

    foreach (vecs[v]) begin
      cur_vec = v;
      run_vec(vecs[v]);
    end
    cur_vec = -1;

    // Asynchronous reset while waiting for a trigger.
    ch_sel = 2'd0; trig_level = 12'h800; trig_rise = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ad_data_in_1 = 12'h100; ad_valid = 1'b1; tick();
    end
    ad_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_wr_en", wr_en, 1);
    #2; rst_n = 1'b0; #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_start", start_addr, 0);
    #2; rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
